io_bist_harness: RTL and testbench

- Synthesizable, parametrised built-in self-test harness for a Tiny Tapeout user design; a hardware version of the cocotb pin-level bench.
- Drives a stimulus bus into the design inputs (ui_in-style) and holds each vector for a configurable settle time.
- Compacts the design outputs (uo_out-style) into a MISR signature and compares it to an expected value, reporting pass/fail.
- Sits beside the user project, so silicon can self-check without an external tester.

---
 rtl/io_bist_harness.sv | 128 ++++++++++++
 tb/tb_io_bist_harness.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/io_bist_harness.sv
// rtl/io_bist_harness.sv - pin-level BIST harness: LFSR/counting stimulus, settle hold, MISR compaction, pass/fail
module io_bist_harness #(
  parameter int IN_W = 8,
  parameter int OUT_W = 8,
  parameter int NUM_VECTORS = 256,
  parameter int SETTLE = 2,
  parameter logic [IN_W-1:0] LFSR_TAPS = 8'hB8,
  parameter logic [OUT_W-1:0] MISR_TAPS = 8'hB8,
  parameter logic [OUT_W-1:0] EXPECTED_SIG = 8'h00
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             mode,
  input  logic [IN_W-1:0]  seed,
  output logic [IN_W-1:0]  stim,
  input  logic [OUT_W-1:0] resp,
  output logic             busy,
  output logic             done,
  output logic             pass,
  output logic [OUT_W-1:0] signature
);

  localparam int VW = $clog2(NUM_VECTORS + 1);
  localparam int HW = (SETTLE < 1) ? 1 : $clog2(SETTLE + 1);
  localparam logic [VW-1:0] LAST_VEC = VW'(NUM_VECTORS - 1);
  localparam logic [HW-1:0] LAST_HOLD = HW'(SETTLE);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_HOLD = 2'd1, S_DONE = 2'd2} state_t;

  state_t state_q, state_d;
  logic [IN_W-1:0] stim_q, stim_d;
  logic [OUT_W-1:0] misr_q, misr_d;
  logic [VW-1:0] vec_cnt_q, vec_cnt_d;
  logic [HW-1:0] hold_cnt_q, hold_cnt_d;
  logic mode_q, mode_d;
  logic pass_q, pass_d;

  logic launch;
  logic sample;
  logic last_sample;

  function automatic logic [IN_W-1:0] galois_in(input logic [IN_W-1:0] s);
    galois_in = (s >> 1) ^ (s[0] ? LFSR_TAPS : '0);
  endfunction

  function automatic logic [OUT_W-1:0] galois_out(input logic [OUT_W-1:0] s);
    galois_out = (s >> 1) ^ (s[0] ? MISR_TAPS : '0);
  endfunction

  assign launch = start && (state_q == S_IDLE || state_q == S_DONE);
  assign sample = (state_q == S_HOLD) && (hold_cnt_q == LAST_HOLD);
  assign last_sample = sample && (vec_cnt_q == LAST_VEC);

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      stim_q     <= '0;
      misr_q     <= '0;
      vec_cnt_q  <= '0;
      hold_cnt_q <= '0;
      mode_q     <= 1'b0;
      pass_q     <= 1'b0;
    end else begin
      state_q    <= state_d;
      stim_q     <= stim_d;
      misr_q     <= misr_d;
      vec_cnt_q  <= vec_cnt_d;
      hold_cnt_q <= hold_cnt_d;
      mode_q     <= mode_d;
      pass_q     <= pass_d;
    end
  end

  // abort outranks start, and both outrank normal sequencing
  always_comb begin
    state_d = state_q;
    if (abort) begin
      state_d = S_IDLE;
    end else if (launch) begin
      state_d = S_HOLD;
    end else if (last_sample) begin
      state_d = S_DONE;
    end
  end

  always_comb begin
    stim_d     = stim_q;
    misr_d     = misr_q;
    vec_cnt_d  = vec_cnt_q;
    hold_cnt_d = hold_cnt_q;
    mode_d     = mode_q;
    pass_d     = pass_q;
    if (abort) begin
      pass_d = 1'b0;
    end else if (launch) begin
      misr_d     = '0;
      vec_cnt_d  = '0;
      hold_cnt_d = '0;
      mode_d     = mode;
      pass_d     = 1'b0;
      // an all-zero LFSR state would never advance
      stim_d     = (!mode && seed == '0) ? IN_W'(1) : seed;
    end else if (state_q == S_HOLD) begin
      if (sample) begin
        misr_d     = galois_out(misr_q) ^ resp;
        stim_d     = mode_q ? stim_q + IN_W'(1) : galois_in(stim_q);
        vec_cnt_d  = vec_cnt_q + VW'(1);
        hold_cnt_d = '0;
        if (last_sample) begin
          pass_d = (misr_d == EXPECTED_SIG);
        end
      end else begin
        hold_cnt_d = hold_cnt_q + HW'(1);
      end
    end
  end

  always_comb begin
    busy      = (state_q == S_HOLD);
    done      = (state_q == S_DONE);
    pass      = pass_q;
    stim      = stim_q;
    signature = misr_q;
  end

endmodule

// File: tb/tb_io_bist_harness.sv
// tb/tb_io_bist_harness.sv - directed bench for io_bist_harness across four parameter sets
module tb_io_bist_harness;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst = 1'b1;

  logic       start0 = 1'b0, abort0 = 1'b0, mode0 = 1'b0;
  logic [7:0] seed0 = 8'h00, resp0 = 8'h00;
  logic [7:0] stim0, sig0;
  logic       busy0, done0, pass0;

  logic       start1 = 1'b0;
  logic [7:0] stim1, sig1, stim2, sig2;
  logic       busy1, done1, pass1, busy2, done2, pass2;

  logic       start3 = 1'b0;
  logic [7:0] stim3, sig3;
  logic       busy3, done3, pass3;

  io_bist_harness u0 (
    .clk(clk), .rst(rst), .start(start0), .abort(abort0), .mode(mode0), .seed(seed0),
    .stim(stim0), .resp(resp0), .busy(busy0), .done(done0), .pass(pass0), .signature(sig0)
  );

  io_bist_harness #(.NUM_VECTORS(3), .SETTLE(0), .EXPECTED_SIG(8'h5C)) u1 (
    .clk(clk), .rst(rst), .start(start1), .abort(1'b0), .mode(1'b0), .seed(8'h01),
    .stim(stim1), .resp(stim1), .busy(busy1), .done(done1), .pass(pass1), .signature(sig1)
  );

  io_bist_harness #(.NUM_VECTORS(3), .SETTLE(0), .EXPECTED_SIG(8'h5D)) u2 (
    .clk(clk), .rst(rst), .start(start1), .abort(1'b0), .mode(1'b0), .seed(8'h01),
    .stim(stim2), .resp(stim2), .busy(busy2), .done(done2), .pass(pass2), .signature(sig2)
  );

  io_bist_harness #(.NUM_VECTORS(4), .SETTLE(0)) u3 (
    .clk(clk), .rst(rst), .start(start3), .abort(1'b0), .mode(1'b1), .seed(8'hFE),
    .stim(stim3), .resp(8'h00), .busy(busy3), .done(done3), .pass(pass3), .signature(sig3)
  );

  int total = 0;
  int bad = 0;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  logic [7:0] seq [6];
  int cnt;
  logic saw_zero;

  initial begin
    seq[0] = 8'h01; seq[1] = 8'hB8; seq[2] = 8'h5C;
    seq[3] = 8'h2E; seq[4] = 8'h17; seq[5] = 8'hB3;

    step();
    step();
    chk("rst_stim", stim0, 8'h00);
    chk("rst_sig", sig0, 8'h00);
    chk("rst_busy", busy0, 1'b0);
    chk("rst_done", done0, 1'b0);
    chk("rst_pass", pass0, 1'b0);
    rst = 1'b0;
    step();

    // short loopback and counting-wrap instances
    start1 = 1'b1;
    start3 = 1'b1;
    step();
    start1 = 1'b0;
    start3 = 1'b0;
    chk("lb_stim0", stim1, 8'h01);
    chk("lb_sig0", sig1, 8'h00);
    chk("lb_busy0", busy1, 1'b1);
    chk("cnt_stim0", stim3, 8'hFE);
    step();
    chk("lb_sig1", sig1, 8'h01);
    chk("lb_stim1", stim1, 8'hB8);
    chk("cnt_stim1", stim3, 8'hFF);
    step();
    chk("lb_sig2", sig1, 8'h00);
    chk("lb_busy2", busy1, 1'b1);
    chk("cnt_stim2", stim3, 8'h00);
    step();
    chk("lb_sig3", sig1, 8'h5C);
    chk("lb_done", done1, 1'b1);
    chk("lb_busy3", busy1, 1'b0);
    chk("lb_pass_5c", pass1, 1'b1);
    chk("lb_sig_5d", sig2, 8'h5C);
    chk("lb_pass_5d", pass2, 1'b0);
    chk("lb_done_5d", done2, 1'b1);
    chk("cnt_stim3", stim3, 8'h01);
    chk("cnt_busy3", busy3, 1'b1);
    step();
    chk("cnt_done", done3, 1'b1);
    chk("cnt_sig", sig3, 8'h00);
    chk("cnt_pass", pass3, 1'b1);
    chk("cnt_stim_after", stim3, 8'h02);

    // default instance: LFSR sequence and run length
    mode0 = 1'b0;
    seed0 = 8'h01;
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    cnt = 0;
    for (int i = 0; i < 1000 && busy0; i++) begin
      if (i < 18) chk("lfsr_seq", stim0, seq[i/3]);
      cnt++;
      step();
    end
    chk("lfsr_busy_len", cnt, 768);
    chk("lfsr_done", done0, 1'b1);
    chk("lfsr_pass", pass0, 1'b1);
    step();
    chk("lfsr_done_sticky", done0, 1'b1);

    // zero-seed guard
    seed0 = 8'h00;
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    chk("zs_first", stim0, 8'h01);
    saw_zero = 1'b0;
    cnt = 0;
    for (int i = 0; i < 1000 && busy0; i++) begin
      if (stim0 == 8'h00) saw_zero = 1'b1;
      cnt++;
      step();
    end
    chk("zs_never_zero", saw_zero, 1'b0);
    chk("zs_busy_len", cnt, 768);

    // abort together with start
    resp0 = 8'hFF;
    seed0 = 8'h01;
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    for (int i = 0; i < 8; i++) step();
    chk("ab_stim_pre", stim0, 8'h5C);
    chk("ab_sig_pre", sig0, 8'h38);
    abort0 = 1'b1;
    start0 = 1'b1;
    step();
    abort0 = 1'b0;
    start0 = 1'b0;
    chk("ab_busy", busy0, 1'b0);
    chk("ab_done", done0, 1'b0);
    chk("ab_pass", pass0, 1'b0);
    chk("ab_stim_kept", stim0, 8'h5C);
    chk("ab_sig_kept", sig0, 8'h38);
    step();
    chk("ab_idle", busy0, 1'b0);

    // clean restart in counting mode, with a start pulse while busy
    resp0 = 8'h00;
    mode0 = 1'b1;
    seed0 = 8'h2E;
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    chk("rs_sig", sig0, 8'h00);
    chk("rs_stim", stim0, 8'h2E);
    chk("rs_busy", busy0, 1'b1);
    cnt = 0;
    for (int i = 0; i < 1000 && busy0; i++) begin
      start0 = (i == 19);
      cnt++;
      step();
    end
    start0 = 1'b0;
    chk("rs_busy_len", cnt, 768);
    chk("rs_done", done0, 1'b1);
    chk("rs_stim_end", stim0, 8'h2E);
    chk("rs_pass", pass0, 1'b1);

    // reset mid-run beats start and abort
    resp0 = 8'hFF;
    mode0 = 1'b0;
    seed0 = 8'h01;
    start0 = 1'b1;
    step();
    start0 = 1'b0;
    for (int i = 0; i < 49; i++) step();
    rst = 1'b1;
    start0 = 1'b1;
    abort0 = 1'b1;
    step();
    rst = 1'b0;
    start0 = 1'b0;
    abort0 = 1'b0;
    chk("mr_stim", stim0, 8'h00);
    chk("mr_sig", sig0, 8'h00);
    chk("mr_busy", busy0, 1'b0);
    chk("mr_done", done0, 1'b0);
    chk("mr_pass", pass0, 1'b0);
    step();
    chk("mr_idle", busy0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
